vector_sequencer: RTL and testbench
===================================

Name: vector_sequencer

Overview:
- Synthesizable, parametrised stimulus/check engine for exercising a multicycle controller (op/funct/zero in, state out) or any handshaking DUT.
- Holds a loadable vector memory. Each entry is {stimulus, expected response, check-enable}.
- Issues one vector per DUT-ready cycle, waits for the DUT response, compares it against the expected value, and accumulates error statistics.
- Adds three behaviours that free-running vector indexing does not have: handshake-correct issue, a response timeout, and optional looping.

Parameters:
- IN_W, 13: stimulus width; default is op[5:0], funct[5:0], zero.
- OUT_W, 4: DUT response width, e.g. controller state.
- DEPTH, 16: number of vector entries.
- AW, $clog2(DEPTH): vector address width.
- TIMEOUT, 64: maximum cycles to wait for a response before aborting.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- load_en, input, 1: write enable for one vector entry.
- load_addr, input, AW: entry address for load.
- load_data, input, IN_W+OUT_W+1: entry value {stim, expect, chk}; chk is the LSB.
- start, input, 1: begin a run from entry 0.
- stop, input, 1: abort the run.
- num_vec, input, AW+1: number of vectors to run, sampled on start.
- loop_en, input, 1: wrap to entry 0 after the last vector; sampled on start.
- dut_ready, input, 1: DUT can accept a stimulus (e.g. controller state == fetch).
- dut_resp_valid, input, 1: DUT response is valid this cycle.
- dut_resp, input, OUT_W: DUT response value.
- stim, output, IN_W: registered stimulus to the DUT.
- stim_valid, output, 1: one-cycle pulse when stim is updated.
- busy, output, 1: a run is in progress.
- done, output, 1: level; run finished, held until the next start.
- mismatch, output, 1: one-cycle pulse on each failed compare.
- timeout, output, 1: sticky; the run aborted because of a timeout.
- err_count, output, ERR_W: number of errors in the run; saturating.
- first_err_idx, output, AW: index of the first failing vector.
- cur_idx, output, AW: index of the current vector.

Behaviour:
- Reset: async; every output is 0 and the FSM goes to IDLE. Vector memory is not reset; its contents are retained.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE. All outputs are registered.
- IDLE:
  - start with num_vec == 0 -> DONE, with err_count = 0.
  - start with num_vec != 0 -> ISSUE, with cur_idx = 0 and errors cleared.
  - num_vec > DEPTH is clamped to DEPTH.
- ISSUE: wait for dut_ready. In the cycle it is sampled high, load stim from mem[cur_idx], pulse stim_valid for 1 cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - dut_resp_valid -> latch dut_resp, go to CHECK.
  - Timeout counter reaches TIMEOUT-1 without dut_resp_valid -> set timeout, err_count+1, record first_err_idx if this is the first error, go to DONE.
- CHECK (1 cycle):
  - If chk = 1 and resp != expect: pulse mismatch, err_count+1 (saturating at all-ones), record first_err_idx if this is the first error.
  - If cur_idx is the last vector and loop_en = 0 -> DONE.
  - If cur_idx is the last vector and loop_en = 1 -> cur_idx = 0, go to ISSUE.
  - Otherwise cur_idx+1, go to ISSUE.
- DONE: done = 1 and busy = 0. start -> behaves as start from IDLE.
- Latency: at least 3 cycles per vector (ISSUE→WAIT→CHECK) when dut_ready and the response arrive immediately.
- stop in any busy state -> DONE on the next edge. stop takes priority over simultaneous resp/ready. Counters are preserved.
- start while busy is ignored. load_en while busy is ignored and the write is dropped.
- dut_ready held high does not re-issue. A new vector is issued only from ISSUE.
- dut_resp_valid outside WAIT is ignored.
- busy = 1 in ISSUE, WAIT and CHECK.

Decomposition:
- Package seq_pkg:
  - seq_state_t enum.
  - Field offset localparams for the stim, expect and chk slices.
  - Function vec_fields() to unpack an entry.
- Sub-module vector_mem: DEPTH x (IN_W+OUT_W+1); synchronous write, asynchronous read; no reset.

Test Plan:
- Load 3 vectors with chk=1, expects 0,0,0; num_vec=3; dut_ready high; DUT responds 2 cycles after stim_valid with the matching value -> 3 stim_valid pulses, done, err_count=0, mismatch never asserted.
- Vector 1 expect=4'h5, DUT returns 4'h3 -> one mismatch pulse, err_count=1, first_err_idx=1. The same mismatch on a chk=0 entry -> no error.
- DUT never asserts dut_resp_valid after vector 0 -> timeout=1 at cycle TIMEOUT after issue, err_count=1, done, cur_idx=0.
- loop_en=1, num_vec=2, stop asserted after 5 issues -> stim indices 0,1,0,1,0, then DONE; start and load_en pulsed while busy have no effect.
- num_vec=0 -> done one cycle after start. num_vec=20 with DEPTH=16 -> exactly 16 issues.
- reset asserted mid-WAIT -> all outputs 0 and FSM in IDLE in the same cycle; memory retained, and a rerun reproduces the same stimulus.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and entry layout for the vector sequencer.
// An entry is {stim, expect, chk} with chk in the LSB.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } seq_state_t;

  // Fields are unpacked into fixed maximum-width containers; callers slice
  // the low bits they need.
  localparam int VEC_MAX_W = 32;
  localparam int ENT_MAX_W = 2 * VEC_MAX_W + 1;
  localparam int CHK_LSB   = 0;
  localparam int EXP_LSB   = 1;

  typedef struct packed {
    logic [VEC_MAX_W-1:0] stim;
    logic [VEC_MAX_W-1:0] exp_v;
    logic                 chk;
  } vec_fields_t;

  function automatic vec_fields_t vec_fields(input logic [ENT_MAX_W-1:0] ent,
                                             input int out_w);
    vec_fields_t          f;
    logic [ENT_MAX_W-1:0] mask;
    logic [ENT_MAX_W-1:0] sh;
    mask    = (ENT_MAX_W'(1) << out_w) - ENT_MAX_W'(1);
    f.chk   = ent[CHK_LSB];
    sh      = (ent >> EXP_LSB) & mask;
    f.exp_v = sh[VEC_MAX_W-1:0];
    sh      = ent >> (EXP_LSB + out_w);
    f.stim  = sh[VEC_MAX_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/vector_mem.sv
// Vector storage: synchronous write, asynchronous read, contents survive reset.
module vector_mem #(
  parameter int W     = 18,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vector_sequencer.sv
// Stimulus/check engine: issues stored vectors to a handshaking DUT, compares
// responses, and keeps saturating error statistics with timeout and looping.
module vector_sequencer
  import seq_pkg::*;
#(
  parameter int IN_W    = 13,
  parameter int OUT_W   = 4,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [AW-1:0]           load_addr,
  input  logic [IN_W+OUT_W:0]     load_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic [AW:0]             num_vec,
  input  logic                    loop_en,
  input  logic                    dut_ready,
  input  logic                    dut_resp_valid,
  input  logic [OUT_W-1:0]        dut_resp,
  output logic [IN_W-1:0]         stim,
  output logic                    stim_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    mismatch,
  output logic                    timeout,
  output logic [ERR_W-1:0]        err_count,
  output logic [AW-1:0]           first_err_idx,
  output logic [AW-1:0]           cur_idx
);

  localparam int            E_W     = IN_W + OUT_W + 1;
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);

  seq_state_t       state;
  logic [TW-1:0]    tcnt;
  logic [AW:0]      nvec;
  logic             loop_r;
  logic [OUT_W-1:0] resp_p0;
  logic [E_W-1:0]   ent;
  vec_fields_t      f;
  logic             idle_like;
  logic             last;
  logic             bad;
  logic             unused_hi;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign idle_like = (state == S_IDLE) || (state == S_DONE);

  vector_mem #(.W(E_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (load_en && idle_like),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (cur_idx),
    .rdata (ent)
  );

  assign f         = vec_fields({{(ENT_MAX_W-E_W){1'b0}}, ent}, OUT_W);
  assign bad       = f.chk && (resp_p0 != f.exp_v[OUT_W-1:0]);
  assign last      = ({1'b0, cur_idx} == (nvec - (AW+1)'(1)));
  assign unused_hi = ^{f.stim[VEC_MAX_W-1:IN_W], f.exp_v[VEC_MAX_W-1:OUT_W]};

  // response capture stage: datapath only, no reset
  always_ff @(posedge clk) begin
    if (state == S_WAIT && dut_resp_valid && !stop) resp_p0 <= dut_resp;
  end

  // control FSM: all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      stim          <= '0;
      stim_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      cur_idx       <= '0;
      tcnt          <= '0;
      nvec          <= '0;
      loop_r        <= 1'b0;
    end else begin
      stim_valid <= 1'b0;
      mismatch   <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cur_idx       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            timeout       <= 1'b0;
            loop_r        <= loop_en;
            nvec          <= (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
            if (num_vec == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_ISSUE;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        default: begin
          if (stop) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            case (state)
              S_ISSUE: begin
                if (dut_ready) begin
                  stim       <= f.stim[IN_W-1:0];
                  stim_valid <= 1'b1;
                  tcnt       <= '0;
                  state      <= S_WAIT;
                end
              end
              S_WAIT: begin
                if (dut_resp_valid) begin
                  state <= S_CHECK;
                end else if (tcnt == T_LAST) begin
                  timeout   <= 1'b1;
                  err_count <= sat_inc(err_count);
                  if (err_count == '0) first_err_idx <= cur_idx;
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  tcnt <= tcnt + TW'(1);
                end
              end
              S_CHECK: begin
                if (bad) begin
                  mismatch  <= 1'b1;
                  err_count <= sat_inc(err_count);
                  if (err_count == '0) first_err_idx <= cur_idx;
                end
                if (last && !loop_r) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  cur_idx <= last ? '0 : cur_idx + AW'(1);
                  state   <= S_ISSUE;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed plus randomized bench for vector_sequencer with a behavioural
// responder and an issue-list reference model.
module tb_vector_sequencer;

  localparam int IN_W    = 13;
  localparam int OUT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;
  localparam int ERR_W   = 8;

  logic                clk;
  logic                reset;
  logic                load_en;
  logic [AW-1:0]       load_addr;
  logic [IN_W+OUT_W:0] load_data;
  logic                start;
  logic                stop;
  logic [AW:0]         num_vec;
  logic                loop_en;
  logic                dut_ready;
  logic                dut_resp_valid;
  logic [OUT_W-1:0]    dut_resp;
  logic [IN_W-1:0]     stim;
  logic                stim_valid;
  logic                busy;
  logic                done;
  logic                mismatch;
  logic                timeout;
  logic [ERR_W-1:0]    err_count;
  logic [AW-1:0]       first_err_idx;
  logic [AW-1:0]       cur_idx;

  vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW),
    .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stop(stop), .num_vec(num_vec),
    .loop_en(loop_en), .dut_ready(dut_ready), .dut_resp_valid(dut_resp_valid),
    .dut_resp(dut_resp), .stim(stim), .stim_valid(stim_valid), .busy(busy),
    .done(done), .mismatch(mismatch), .timeout(timeout), .err_count(err_count),
    .first_err_idx(first_err_idx), .cur_idx(cur_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] ex;
    logic             chk;
  } ent_t;

  ent_t            model [DEPTH];
  logic [IN_W-1:0] issued_q [$];
  int              mm_cnt;
  int              vld_cnt;
  int              vectors;
  int              miscompares;
  int              resp_delay;
  bit              resp_on;

  // observed issue list and pulse counts
  always @(negedge clk) begin
    if (stim_valid) begin
      issued_q.push_back(stim);
      vld_cnt++;
    end
    if (mismatch) mm_cnt++;
  end

  // emulated DUT: answers with the low nibble of the stimulus
  initial begin : responder
    dut_resp_valid = 1'b0;
    dut_resp       = '0;
    forever begin
      @(negedge clk);
      if (stim_valid && resp_on) begin
        repeat (resp_delay) @(negedge clk);
        dut_resp       = stim[OUT_W-1:0];
        dut_resp_valid = 1'b1;
        @(negedge clk);
        dut_resp_valid = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int a, input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e,
                      input logic c);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = {s, e, c};
    step();
    load_en   = 1'b0;
    model[a]  = '{s, e, c};
  endtask

  task automatic run(input int n, input bit lp);
    issued_q.delete();
    mm_cnt  = 0;
    vld_cnt = 0;
    num_vec = (AW+1)'(n);
    loop_en = lp;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      step();
      k++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  // Expected stimulus i is entry (i mod n); errors are counted over the
  // vectors whose response was actually compared.
  task automatic check_run(input string tag, input int n, input int issues, input int checks);
    int   nc;
    int   err;
    int   first;
    ent_t e;
    step(2);
    nc    = (n > DEPTH) ? DEPTH : n;
    err   = 0;
    first = 0;
    check({tag, "_issues"}, issued_q.size(), issues);
    check({tag, "_vld"}, vld_cnt, issues);
    if (nc > 0) begin
      for (int k = 0; k < issued_q.size() && k < issues; k++)
        check($sformatf("%s_stim%0d", tag, k), issued_q[k], model[k % nc].stim);
      for (int k = 0; k < checks; k++) begin
        e = model[k % nc];
        if (e.chk && e.ex != e.stim[OUT_W-1:0]) begin
          if (err == 0) first = k % nc;
          err++;
        end
      end
    end
    check({tag, "_err"}, err_count, (err > 255) ? 255 : err);
    check({tag, "_first"}, first_err_idx, first);
    check({tag, "_mm"}, mm_cnt, err);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : main
    int              k;
    int              n;
    logic [IN_W-1:0] s;
    vectors     = 0;
    miscompares = 0;
    mm_cnt      = 0;
    vld_cnt     = 0;
    reset       = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    num_vec     = '0;
    loop_en     = 1'b0;
    dut_ready   = 1'b1;
    resp_on     = 1'b1;
    resp_delay  = 2;
    step(2);
    check("rst_outs", {stim, stim_valid, busy, done, mismatch, timeout,
                       err_count, first_err_idx, cur_idx}, 0);
    reset = 1'b0;
    step(2);

    // all-matching three-vector run
    for (int i = 0; i < 3; i++) begin
      s = IN_W'($urandom);
      s[OUT_W-1:0] = '0;
      load(i, s, '0, 1'b1);
    end
    run(3, 1'b0);
    check("t1_busy", busy, 1);
    wait_done("t1");
    check_run("t1", 3, 3, 3);
    check("t1_idx", cur_idx, 2);

    // vector 1 answers 3 against an expected 5
    s = IN_W'($urandom);
    s[OUT_W-1:0] = 4'h3;
    load(1, s, 4'h5, 1'b1);
    run(3, 1'b0);
    wait_done("t2a");
    check_run("t2a", 3, 3, 3);
    check("t2a_err1", err_count, 1);
    check("t2a_first1", first_err_idx, 1);

    load(1, s, 4'h5, 1'b0);
    run(3, 1'b0);
    wait_done("t2b");
    check_run("t2b", 3, 3, 3);

    // no response ever arrives
    resp_on = 1'b0;
    run(3, 1'b0);
    k = 0;
    while (!stim_valid && k < 20) begin
      step();
      k++;
    end
    check("t3_issue", stim_valid, 1);
    step(TIMEOUT - 1);
    check("t3_pending", {timeout, busy}, 2'b01);
    step();
    check("t3_timeout", {timeout, done, busy}, 3'b110);
    check("t3_err", err_count, 1);
    check("t3_idx", cur_idx, 0);
    check("t3_first", first_err_idx, 0);
    resp_on = 1'b1;

    // looping run stopped after five issues; start/load while busy dropped
    step(20);
    resp_delay = 0;
    for (int i = 0; i < 2; i++) begin
      s = IN_W'($urandom);
      load(i, s, s[OUT_W-1:0], 1'b1);
    end
    run(2, 1'b1);
    k = 0;
    while (issued_q.size() < 2 && k < 200) begin
      step();
      k++;
    end
    start     = 1'b1;
    num_vec   = '0;
    loop_en   = 1'b0;
    load_en   = 1'b1;
    load_addr = '0;
    load_data = '1;
    step();
    start   = 1'b0;
    load_en = 1'b0;
    k = 0;
    while (issued_q.size() < 5 && k < 200) begin
      step();
      k++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(10);
    check("t4_state", {done, busy}, 2'b10);
    check_run("t4", 2, 5, 4);
    check("t4_idx", cur_idx, 0);

    // asynchronous reset while waiting for a response
    step(20);
    resp_delay = 10;
    run(3, 1'b0);
    k = 0;
    while (issued_q.size() < 1 && k < 200) begin
      step();
      k++;
    end
    step(2);
    check("t6_wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_outs", {stim, stim_valid, busy, done, mismatch, timeout,
                          err_count, first_err_idx, cur_idx}, 0);
    step();
    reset = 1'b0;
    step(20);

    // zero-length run
    check("t5_pre", done, 0);
    run(0, 1'b0);
    check("t5_done", {done, busy}, 2'b10);
    check_run("t5", 0, 0, 0);

    // rerun after reset reproduces stored stimulus
    resp_delay = 2;
    run(3, 1'b0);
    wait_done("t6r");
    check_run("t6r", 3, 3, 3);

    // oversize count clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      s = IN_W'($urandom);
      load(i, s, s[OUT_W-1:0], 1'b1);
    end
    run(20, 1'b0);
    wait_done("t7");
    check_run("t7", 20, DEPTH, DEPTH);
    check("t7_idx", cur_idx, DEPTH - 1);

    // randomized tables
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        s = IN_W'($urandom);
        load(i, s, ($urandom_range(0, 1) == 1) ? s[OUT_W-1:0] : OUT_W'($urandom),
             1'($urandom_range(0, 1)));
      end
      n = $urandom_range(1, 20);
      resp_delay = $urandom_range(0, 3);
      run(n, 1'b0);
      wait_done($sformatf("rnd%0d", r));
      check_run($sformatf("rnd%0d", r), n, (n > DEPTH) ? DEPTH : n, (n > DEPTH) ? DEPTH : n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
